// File: rtl/grf_pkg.sv
// Shared constants and helpers for the general register file.
package grf_pkg;

  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

  // True when a read index should pick up the write happening this cycle.
  function automatic logic fwd_hit(input logic                 reset,
                                   input logic                 we,
                                   input logic [REG_IDX_W-1:0] a3,
                                   input logic [REG_IDX_W-1:0] ra);
    return (!reset) && we && (a3 != ZERO_REG) && (ra == a3);
  endfunction

endpackage

// File: rtl/grf.sv
// General register file: 32 x 32-bit, two combinational read ports,
// one synchronous write port, optional write-to-read forwarding and a
// one-stage commit trace.
module grf
  import grf_pkg::*;
#(
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [4:0]  a3,
  input  logic [31:0] wd,
  input  logic [31:0] pc,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_addr,
  output logic [31:0] trace_data
);

  localparam logic bypass_en = (BYPASS != 0);

  logic [DATA_W-1:0]    regs_r [NREG];
  logic [DATA_W-1:0]    rd1_s;
  logic [DATA_W-1:0]    rd2_s;
  logic                 trace_valid_r;
  logic [DATA_W-1:0]    trace_pc_r;
  logic [REG_IDX_W-1:0] trace_addr_r;
  logic [DATA_W-1:0]    trace_data_r;

  // Register storage: reset clears everything, writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we && (a3 != ZERO_REG)) begin
      regs_r[a3] <= wd;
    end
  end

  // Read port 1: r0 reads zero, optional forward of the in-flight write.
  always_comb begin
    rd1_s = regs_r[a1];
    if (a1 == ZERO_REG) begin
      rd1_s = 32'd0;
    end else if (bypass_en && fwd_hit(reset, we, a3, a1)) begin
      rd1_s = wd;
    end else begin
      rd1_s = regs_r[a1];
    end
  end

  // Read port 2: same rules as port 1 so equal indices give equal data.
  always_comb begin
    rd2_s = regs_r[a2];
    if (a2 == ZERO_REG) begin
      rd2_s = 32'd0;
    end else if (bypass_en && fwd_hit(reset, we, a3, a2)) begin
      rd2_s = wd;
    end else begin
      rd2_s = regs_r[a2];
    end
  end

  // Trace stage: one pulse per accepted write, payload held between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      trace_valid_r <= 1'b0;
      trace_pc_r    <= 32'd0;
      trace_addr_r  <= 5'd0;
      trace_data_r  <= 32'd0;
    end else if (we) begin
      trace_valid_r <= 1'b1;
      trace_pc_r    <= pc;
      trace_addr_r  <= a3;
      trace_data_r  <= (a3 == ZERO_REG) ? 32'd0 : wd;
    end else begin
      trace_valid_r <= 1'b0;
    end
  end

  assign rd1         = rd1_s;
  assign rd2         = rd2_s;
  assign trace_valid = trace_valid_r;
  assign trace_pc    = trace_pc_r;
  assign trace_addr  = trace_addr_r;
  assign trace_data  = trace_data_r;

endmodule

// File: tb/tb_grf.sv
// Directed table-driven bench for grf; runs a forwarding and a
// non-forwarding instance side by side on the same stimulus.
module tb_grf;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  a3;
  logic [31:0] wd;
  logic [31:0] pc;

  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        tv_b, tv_n;
  logic [31:0] tpc_b, tpc_n, tdata_b, tdata_n;
  logic [4:0]  taddr_b, taddr_n;

  int pass_cnt;
  int total_cnt;

  grf #(.BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset), .we(we), .a1(a1), .a2(a2), .a3(a3),
    .wd(wd), .pc(pc), .rd1(rd1_b), .rd2(rd2_b),
    .trace_valid(tv_b), .trace_pc(tpc_b), .trace_addr(taddr_b),
    .trace_data(tdata_b)
  );

  grf #(.BYPASS(0)) dut_nobyp (
    .clk(clk), .reset(reset), .we(we), .a1(a1), .a2(a2), .a3(a3),
    .wd(wd), .pc(pc), .rd1(rd1_n), .rd2(rd2_n),
    .trace_valid(tv_n), .trace_pc(tpc_n), .trace_addr(taddr_n),
    .trace_data(tdata_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        reset;
    logic        we;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [31:0] e_rd1_b;
    logic [31:0] e_rd2_b;
    logic [31:0] e_rd1_n;
    logic [31:0] e_rd2_n;
    logic        e_tv;
    logic [31:0] e_tpc;
    logic [4:0]  e_taddr;
    logic [31:0] e_tdata;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total_cnt++;
    if (act === exp_v) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic check_trace(input string tag, input logic e_tv, input logic [31:0] e_tpc,
                             input logic [4:0] e_taddr, input logic [31:0] e_tdata);
    check({tag, " trace_valid byp"}, {31'd0, tv_b}, {31'd0, e_tv});
    check({tag, " trace_valid nobyp"}, {31'd0, tv_n}, {31'd0, e_tv});
    check({tag, " trace_pc"}, tpc_b, e_tpc);
    check({tag, " trace_addr"}, {27'd0, taddr_b}, {27'd0, e_taddr});
    check({tag, " trace_data"}, tdata_b, e_tdata);
    check({tag, " trace_data nobyp"}, tdata_n, e_tdata);
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] x1, input logic [4:0] x2,
                       input logic [4:0] x3, input logic [31:0] d, input logic [31:0] p);
    reset = r; we = w; a1 = x1; a2 = x2; a3 = x3; wd = d; pc = p;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);

    //          rst   we    a1     a2     a3     wd            pc
    //          rd1_b         rd2_b         rd1_n         rd2_n
    //          tv    tpc           taddr  tdata
    vecs[0]  = '{1'b1, 1'b0, 5'd5,  5'd31, 5'd0,  32'h0,        32'h0,
                 32'h0,        32'h0,        32'h0,        32'h0,
                 1'b0, 32'h0,        5'd0,  32'h0};
    vecs[1]  = '{1'b0, 1'b0, 5'd5,  5'd31, 5'd0,  32'h0,        32'h0,
                 32'h0,        32'h0,        32'h0,        32'h0,
                 1'b0, 32'h0,        5'd0,  32'h0};
    vecs[2]  = '{1'b0, 1'b1, 5'd1,  5'd2,  5'd8,  32'h12345678, 32'h3000,
                 32'h0,        32'h0,        32'h0,        32'h0,
                 1'b1, 32'h3000,     5'd8,  32'h12345678};
    vecs[3]  = '{1'b0, 1'b0, 5'd8,  5'd8,  5'd0,  32'h0,        32'h0,
                 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678,
                 1'b0, 32'h3000,     5'd8,  32'h12345678};
    vecs[4]  = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 32'h3004,
                 32'h0,        32'h0,        32'h0,        32'h0,
                 1'b1, 32'h3004,     5'd0,  32'h0};
    vecs[5]  = '{1'b0, 1'b1, 5'd9,  5'd8,  5'd9,  32'hA5A5A5A5, 32'h3008,
                 32'hA5A5A5A5, 32'h12345678, 32'h0,        32'h12345678,
                 1'b1, 32'h3008,     5'd9,  32'hA5A5A5A5};
    vecs[6]  = '{1'b0, 1'b1, 5'd9,  5'd9,  5'd9,  32'h5A5A5A5A, 32'h300C,
                 32'h5A5A5A5A, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'hA5A5A5A5,
                 1'b1, 32'h300C,     5'd9,  32'h5A5A5A5A};
    vecs[7]  = '{1'b0, 1'b0, 5'd9,  5'd0,  5'd9,  32'h0,        32'h0,
                 32'h5A5A5A5A, 32'h0,        32'h5A5A5A5A, 32'h0,
                 1'b0, 32'h300C,     5'd9,  32'h5A5A5A5A};
    vecs[8]  = '{1'b0, 1'b1, 5'd4,  5'd4,  5'd4,  32'h11,       32'h3010,
                 32'h11,       32'h11,       32'h0,        32'h0,
                 1'b1, 32'h3010,     5'd4,  32'h11};
    vecs[9]  = '{1'b1, 1'b1, 5'd4,  5'd9,  5'd4,  32'h7,        32'h3014,
                 32'h11,       32'h5A5A5A5A, 32'h11,       32'h5A5A5A5A,
                 1'b0, 32'h0,        5'd0,  32'h0};
    vecs[10] = '{1'b0, 1'b0, 5'd4,  5'd9,  5'd0,  32'h0,        32'h0,
                 32'h0,        32'h0,        32'h0,        32'h0,
                 1'b0, 32'h0,        5'd0,  32'h0};

    // Flush power-up state before the table.
    repeat (2) @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].reset, vecs[i].we, vecs[i].a1, vecs[i].a2, vecs[i].a3, vecs[i].wd, vecs[i].pc);
      #1;
      check($sformatf("v%0d rd1 byp", i), rd1_b, vecs[i].e_rd1_b);
      check($sformatf("v%0d rd2 byp", i), rd2_b, vecs[i].e_rd2_b);
      check($sformatf("v%0d rd1 nobyp", i), rd1_n, vecs[i].e_rd1_n);
      check($sformatf("v%0d rd2 nobyp", i), rd2_n, vecs[i].e_rd2_n);
      @(posedge clk);
      #1;
      check_trace($sformatf("v%0d", i), vecs[i].e_tv, vecs[i].e_tpc, vecs[i].e_taddr, vecs[i].e_tdata);
    end

    // Reset, then back-to-back writes starting on the first free edge.
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 5'd0, 5'd0, k[4:0], {16'h0, k[7:0], k[7:0]}, 32'h4000 + 32'(4 * (k - 1)));
      @(posedge clk);
      #1;
      check_trace($sformatf("b2b%0d", k), 1'b1, 32'h4000 + 32'(4 * (k - 1)), k[4:0], {16'h0, k[7:0], k[7:0]});
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0);
    #1;
    check("b2b rd1 r1", rd1_b, 32'h0101);
    check("b2b rd2 r2", rd2_b, 32'h0202);
    @(posedge clk);
    #1;
    check_trace("b2b end", 1'b0, 32'h4008, 5'd3, 32'h0303);
    @(negedge clk);
    a1 = 5'd3;
    a2 = 5'd3;
    #1;
    check("b2b rd1 r3", rd1_n, 32'h0303);
    check("b2b rd2 r3", rd2_n, 32'h0303);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/grf.md
GRF -- requirements
Module: grf

Interface
REQ-001 Parameter: BYPASS, default 1; when 1, a same-cycle write is forwarded to the read ports.
REQ-002 Port: clk, input, 1, single rising-edge clock.
REQ-003 Port: reset, input, 1, synchronous reset, active-high.
REQ-004 Port: we, input, 1, register write enable from the write-back stage.
REQ-005 Port: a1, input, 5, read port 1 register index (rs).
REQ-006 Port: a2, input, 5, read port 2 register index (rt).
REQ-007 Port: a3, input, 5, write register index (output of the write-address select).
REQ-008 Port: wd, input, 32, write data (output of the write-data select).
REQ-009 Port: pc, input, 32, PC of the instruction performing the write, used for trace.
REQ-010 Port: rd1, output, 32, read data 1.
REQ-011 Port: rd2, output, 32, read data 2.
REQ-012 Port: trace_valid, output, 1, one-cycle pulse reporting a completed write.
REQ-013 Port: trace_pc, output, 32, PC of the reported write.
REQ-014 Port: trace_addr, output, 5, register index of the reported write.
REQ-015 Port: trace_data, output, 32, value committed by the reported write.

Function
REQ-016 Storage SHALL be 32 registers of 32 bits, and register 0 SHALL always read 0.
REQ-017 On a rising clk edge with reset=0, we=1 and a3!=0, reg[a3] SHALL take the value of wd, visible from the next cycle.
REQ-018 A write with a3=0 SHALL leave all storage unchanged.
REQ-019 rd1 and rd2 SHALL be combinational functions of a1/a2 and the current storage, with zero latency.
REQ-020 If BYPASS=1, we=1, a3!=0 and a1==a3, rd1 SHALL equal wd in the same cycle; rd2 SHALL behave the same way with a2.
REQ-021 If BYPASS=0, reads SHALL return the pre-write value during the write cycle.
REQ-022 An index of 0 on a read port SHALL return 0 regardless of bypass.
REQ-023 Both read ports addressing the same register SHALL return identical values.
REQ-024 Trace stage: on each edge where reset=0 and we=1, trace_valid SHALL be 1 in the following cycle, with trace_pc=pc, trace_addr=a3, and trace_data=(a3==0 ? 0 : wd).
REQ-025 On an edge where we=0, trace_valid SHALL be 0 in the next cycle, and trace_pc, trace_addr and trace_data SHALL hold their previous values.
REQ-026 Back-to-back writes SHALL produce back-to-back trace pulses, with no drop and no merging.

Reset
REQ-027 On an edge with reset=1, all 32 registers SHALL clear to 0 and trace_valid, trace_pc, trace_addr and trace_data SHALL clear to 0.
REQ-028 reset=1 together with we=1 SHALL perform no write and SHALL produce no trace pulse; reset wins.
REQ-029 Bypass SHALL NOT apply while reset=1; rd1 and rd2 SHALL reflect stored contents only.
REQ-030 After reset deasserts, the first write SHALL be accepted on the first edge.

Structure
REQ-031 Shared package SHALL hold NREG=32, REG_IDX_W=5, DATA_W=32 and the ZERO_REG=0 constant, for use by the write-address select and the decode logic.
REQ-032 No sub-module is needed; storage, bypass and the trace register stage SHALL be implemented inline.

Verification
REQ-033 Reset, then read a1=5, a2=31 -> rd1=0, rd2=0, trace_valid=0.
REQ-034 we=1, a3=8, wd=0x12345678, pc=0x3000 -> next cycle reg[8] reads 0x12345678; trace_valid=1, trace_pc=0x3000, trace_addr=8, trace_data=0x12345678.
REQ-035 we=1, a3=0, wd=0xFFFFFFFF -> rd(0) stays 0; trace_valid=1 with trace_addr=0 and trace_data=0.
REQ-036 BYPASS=1, we=1, a3=a1=9, wd=0xA5A5A5A5 -> rd1=0xA5A5A5A5 in the same cycle; with BYPASS=0, rd1 returns the old value.
REQ-037 reset=1 with we=1, a3=4, wd=7 -> reg[4]=0 and trace_valid=0 in the next cycle.
REQ-038 Writes on 3 consecutive cycles to registers 1, 2, 3 -> trace_valid high for 3 consecutive cycles with trace_addr 1, 2, 3 in order.
